// File: rtl/fifo_rd_stream.sv
// Read-side drain stage for the async FIFO: issues rinc against a 3-entry credit,
// captures registered FIFO data and presents it on a valid/ready stream.
module fifo_rd_stream #(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned CW    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    output logic [DSIZE-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CW-1:0]    pop_count
);

    localparam int unsigned DEPTH = 3;
    localparam int unsigned IW    = 2;

    logic [1:0]       occ_q, occ_d;
    logic             inflight_q, inflight_d;
    logic [IW-1:0]    head_q, head_d;
    logic [IW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DSIZE-1:0] mem_q [DEPTH];
    logic [2:0]       credit_c;
    logic             capture_c;
    logic             pop_c;

    function automatic logic [IW-1:0] idx_inc(input logic [IW-1:0] idx);
        return (idx == IW'(DEPTH - 1)) ? '0 : idx + IW'(1);
    endfunction

    // Read issue and stream outputs depend only on registers and rempty.
    always_comb begin
        credit_c  = 3'(occ_q) + 3'(inflight_q);
        rinc      = !rst && !rempty && (credit_c <= 3'd2);
        m_valid   = (occ_q != 2'd0);
        capture_c = inflight_q;
        pop_c     = m_valid && m_ready;
        unique case (head_q)
            2'd0:    m_data = mem_q[0];
            2'd1:    m_data = mem_q[1];
            default: m_data = mem_q[2];
        endcase
    end

    always_comb begin
        occ_d      = occ_q;
        inflight_d = rinc;
        head_d     = head_q;
        tail_d     = tail_q;
        cnt_d      = cnt_q;
        if (capture_c) begin
            tail_d = idx_inc(tail_q);
        end
        if (pop_c) begin
            head_d = idx_inc(head_q);
            cnt_d  = cnt_q + CW'(1);
        end
        unique case ({capture_c, pop_c})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            cnt_q      <= cnt_d;
        end
    end

    // Buffer storage carries no reset; occ gates its visibility.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (capture_c && (tail_q == IW'(i))) begin
                mem_q[i] <= rdata;
            end
        end
    end

    assign pop_count = cnt_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: queue-based FIFO model, scoreboard of written words,
// and a negedge monitor checking stream order, counter and read credit.
module tb_fifo_rd_stream;

    localparam int unsigned DSIZE = 8;
    localparam int unsigned CW    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             rempty;
    logic [DSIZE-1:0] rdata;
    logic             rinc;
    logic [DSIZE-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic [CW-1:0]    pop_count;

    fifo_rd_stream #(.DSIZE(DSIZE), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .rempty    (rempty),
        .rdata     (rdata),
        .rinc      (rinc),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .pop_count (pop_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [DSIZE-1:0] fifo[$];
    logic [DSIZE-1:0] exp_q[$];
    int               rd_cnt = 0;
    int               hs_cnt = 0;
    logic [CW-1:0]    mcnt = '0;
    logic             prev_stall = 1'b0;
    logic [DSIZE-1:0] prev_data = '0;

    logic             s_rinc;
    logic             s_valid;
    logic [DSIZE-1:0] s_data;
    logic [CW-1:0]    s_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every delivered word must be the next written word that survived reset.
    always @(negedge clk) begin
        if (rst) begin
            hs_cnt     = 0;
            mcnt       = '0;
            prev_stall = 1'b0;
        end else begin
            chk("pop_count", 32'(pop_count), 32'(mcnt));
            if (rinc) chk("rinc_while_empty", 32'(rempty), 32'd0);
            chk("read_credit", 32'((rd_cnt - hs_cnt + int'(rinc)) <= 3), 32'd1);
            if (prev_stall) begin
                chk("valid_held", 32'(m_valid), 32'd1);
                chk("data_held", 32'(m_data), 32'(prev_data));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 32'(m_data), 32'hffff_ffff);
                end else begin
                    chk("stream_data", 32'(m_data), 32'(exp_q.pop_front()));
                end
                hs_cnt++;
                mcnt = mcnt + CW'(1);
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    task automatic push(input logic [DSIZE-1:0] w);
        fifo.push_back(w);
        exp_q.push_back(w);
        rempty = 1'b0;
    endtask

    // One clock: drive ready, snapshot outputs mid-cycle, then perform the FIFO read.
    task automatic cycle(input logic rdy);
        m_ready = rdy;
        @(negedge clk);
        s_rinc  = rinc;
        s_valid = m_valid;
        s_data  = m_data;
        s_cnt   = pop_count;
        @(posedge clk);
        #1;
        if (s_rinc && fifo.size() != 0) begin
            rdata = fifo.pop_front();
            rd_cnt++;
        end
        rempty = (fifo.size() == 0);
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        rd_cnt = 0;
        exp_q  = fifo;
        #1;
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_rinc", 32'(rinc), 32'd0);
        chk("rst_count", 32'(pop_count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int nv, first, last, np, hs;
        bit got;
        bit done[3];
        logic [DSIZE-1:0] want;

        rst = 1'b1; rempty = 1'b1; m_ready = 1'b0; rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("init_valid", 32'(m_valid), 32'd0);
        chk("init_rinc", 32'(rinc), 32'd0);
        chk("init_count", 32'(pop_count), 32'd0);
        rst = 1'b0;
        repeat (2) cycle(1'b1);

        // Single word: rinc in c0, data in c2, count in c3.
        push(8'hA5);
        cycle(1'b1); chk("single_rinc_c0", 32'(s_rinc), 32'd1);
        cycle(1'b1); chk("single_rinc_c1", 32'(s_rinc), 32'd0);
                     chk("single_valid_c1", 32'(s_valid), 32'd0);
        cycle(1'b1); chk("single_valid_c2", 32'(s_valid), 32'd1);
                     chk("single_data_c2", 32'(s_data), 32'hA5);
        cycle(1'b1); chk("single_count_c3", 32'(s_cnt), 32'd1);
                     chk("single_valid_c3", 32'(s_valid), 32'd0);
                     chk("single_rinc_c3", 32'(s_rinc), 32'd0);

        // Streaming: 100 words, one per cycle after a 2-cycle fill.
        for (int i = 0; i < 100; i++) push(DSIZE'(i));
        nv = 0; first = -1; last = -1;
        for (int i = 0; i < 110; i++) begin
            cycle(1'b1);
            if (s_valid) begin
                if (first < 0) first = i;
                last = i;
                nv++;
            end
        end
        chk("stream_first", 32'(first), 32'd2);
        chk("stream_nvalid", 32'(nv), 32'd100);
        chk("stream_contig", 32'(last - first), 32'd99);
        chk("stream_count", 32'(s_cnt), 32'(101 % 16));

        // Backpressure: exactly three reads while stalled, head word held.
        for (int i = 0; i < 10; i++) push(DSIZE'(8'h30 + i));
        np = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0);
            if (s_rinc) np++;
        end
        chk("bp_rinc_pulses", 32'(np), 32'd3);
        chk("bp_valid", 32'(s_valid), 32'd1);
        chk("bp_head", 32'(s_data), 32'h30);
        nv = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1);
            if (s_valid) nv++;
        end
        chk("bp_delivered", 32'(nv), 32'd10);

        // Empty boundary: last word still in flight when rempty rises.
        push(8'h40); push(8'h41);
        np = 0; nv = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1);
            if (s_rinc) np++;
            if (s_valid) nv++;
            if (i == 1) chk("empty_rempty_c1", 32'(rempty), 32'd1);
        end
        chk("empty_rinc_pulses", 32'(np), 32'd2);
        chk("empty_delivered", 32'(nv), 32'd2);

        // Reset mid-stream with two words buffered and one in flight.
        for (int i = 1; i <= 5; i++) push(DSIZE'(i));
        repeat (3) cycle(1'b0);
        push(8'h11); push(8'h22);
        want = fifo[0];
        do_reset();
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            cycle(1'b1);
            if (s_valid) begin
                got = 1'b1;
                chk("reset_first_word", 32'(s_data), 32'(want));
                chk("reset_first_is_04", 32'(s_data), 32'h04);
            end
        end
        if (!got) chk("reset_first_timeout", 32'd0, 32'd1);
        repeat (8) cycle(1'b1);

        // Counter wrap with CW=4: 15, 0, 1 after 15, 16, 17 handshakes.
        do_reset();
        for (int i = 0; i < 17; i++) push(DSIZE'(8'h50 + i));
        hs = 0; done = '{default: 1'b0};
        for (int i = 0; i < 30; i++) begin
            cycle(1'b1);
            if (hs >= 15 && hs <= 17 && !done[hs-15]) begin
                done[hs-15] = 1'b1;
                chk("wrap_count", 32'(s_cnt), 32'(hs % 16));
            end
            if (s_valid) hs++;
        end
        chk("wrap_reached", 32'({done[0], done[1], done[2]}), 32'b111);
        chk("wrap_total", 32'(hs), 32'd17);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) != 0) push(DSIZE'($urandom));
            cycle($urandom_range(0, 99) < 60);
        end
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) cycle(1'b1);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        repeat (2) cycle(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
